// File: rtl/dbus_lsu_pkg.sv
// Purpose: shared data-bus types plus LSU state encoding and alignment check.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package dbus_lsu_pkg;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } ttype_t;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } tsize_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   // Natural alignment: bytes anywhere, halves on even, words on 4-byte boundaries.
   function automatic logic is_aligned(tsize_t size, logic [1:0] lsb);
      case (size)
         BYTE:    is_aligned = 1'b1;
         HALF:    is_aligned = ~lsb[0];
         WORD:    is_aligned = (lsb == 2'b00);
         default: is_aligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/slave_bus_if.sv
// Purpose: single-cycle shared bus (addr/wdata/ttype/tsize out of the initiator, rdata back).
// Latency: read data valid in the same cycle the address is driven; writes commit at the closing edge.
// Backpressure: none, the bus has no wait states.
interface slave_bus_if #(parameter int ADDR_W = 32);
   import dbus_lsu_pkg::*;

   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   ttype_t            ttype;
   tsize_t            tsize;

   modport master (output addr, output wdata, output ttype, output tsize, input rdata);
   modport slave  (input addr, input wdata, input ttype, input tsize, output rdata);
endinterface

// File: rtl/dbus_lsu_load_ext.sv
// Purpose: sign/zero-extend an assembled load word according to access size.
// Latency: combinational.
// Backpressure: none.
// Ports: word (right-justified load data), size, uns (1 = zero-extend), ext (result).
module lsu_load_ext
   import dbus_lsu_pkg::*;
(
   input  logic [31:0] word,
   input  tsize_t      size,
   input  logic        uns,
   output logic [31:0] ext
);

   always_comb begin
      ext = word;
      case (size)
         BYTE:    ext = {{24{~uns & word[7]}},  word[7:0]};
         HALF:    ext = {{16{~uns & word[15]}}, word[15:0]};
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/dbus_lsu.sv
// Purpose: load/store unit driving the data-side bus initiator, one request at a time.
// Latency: aligned 2 cycles accept-to-response; misaligned split N+1 (N = bytes); rejected 1.
// Backpressure: req_ready is high only in IDLE; requests are ignored while busy.
// Ports: clk/rst_n; dbus (bus initiator); req_* (core request, valid/ready);
//        resp_valid (1-cycle pulse), resp_rdata (extended load data, 0 for stores), resp_error.
// Build option: LSU_MISALIGNED_EN splits misaligned accesses into byte transactions;
//        without it misaligned requests are rejected with resp_error and no bus traffic.
module dbus_lsu
   import dbus_lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   slave_bus_if.master       dbus,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  tsize_t            req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_error
);

   lsu_state_t        state;
   logic              we_q;
   logic              uns_q;
   tsize_t            size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       asm_q;
   logic [31:0]       ext;
   logic              aligned_in;
   logic              err_w;

   assign aligned_in = is_aligned(req_size, req_addr[1:0]);

`ifdef LSU_MISALIGNED_EN
   logic       split_q;
   logic [1:0] k_q;
   logic       last_k;

   // Halves split into 2 bytes, words into 4.
   assign last_k = (size_q == HALF) ? (k_q == 2'd1) : (k_q == 2'd3);
   assign err_w  = 1'b0;
`else
   logic err_q;

   assign err_w = err_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= WORD;
         addr_q  <= '0;
         wdata_q <= '0;
         asm_q   <= '0;
`ifdef LSU_MISALIGNED_EN
         split_q <= 1'b0;
         k_q     <= 2'd0;
`else
         err_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  uns_q   <= req_unsigned;
                  size_q  <= req_size;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  asm_q   <= '0;
`ifdef LSU_MISALIGNED_EN
                  split_q <= ~aligned_in;
                  k_q     <= 2'd0;
                  state   <= BUS;
`else
                  // Misaligned requests never reach the bus.
                  err_q   <= ~aligned_in;
                  state   <= aligned_in ? BUS : RESP;
`endif
               end
            end
            BUS: begin
`ifdef LSU_MISALIGNED_EN
               if (split_q) begin
                  // Byte k of a little-endian split lands in bits [8k+7:8k].
                  asm_q[{k_q, 3'b000} +: 8] <= dbus.rdata[7:0];
                  if (last_k) state <= RESP;
                  else        k_q   <= k_q + 2'd1;
               end else begin
                  asm_q <= dbus.rdata;
                  state <= RESP;
               end
`else
               asm_q <= dbus.rdata;
               state <= RESP;
`endif
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Bus outputs park at READ/WORD/0 whenever no transaction is in flight.
   always_comb begin
      dbus.addr  = '0;
      dbus.wdata = '0;
      dbus.ttype = READ;
      dbus.tsize = WORD;
      if (state == BUS) begin
         dbus.ttype = we_q ? WRITE : READ;
         dbus.addr  = addr_q;
         dbus.tsize = size_q;
         dbus.wdata = wdata_q;
`ifdef LSU_MISALIGNED_EN
         if (split_q) begin
            // Address wraps naturally at the top of the address space.
            dbus.addr  = addr_q + ADDR_W'(k_q);
            dbus.tsize = BYTE;
            dbus.wdata = {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
         end
`endif
      end
   end

   lsu_load_ext u_ext (
      .word (asm_q),
      .size (size_q),
      .uns  (uns_q),
      .ext  (ext)
   );

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_error = resp_valid & err_w;
   assign resp_rdata = (resp_valid && !we_q && !err_w) ? ext : 32'h0;

endmodule
